mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serial memory controller and arbiter sitting between the core and the 8-bit memory bus. It shares the single RAM/IO port between the instruction-fetch requester (always 4-byte reads) and the load/store requester (1/2/4-byte reads or writes). It sequences the pipelined 2-cycle read protocol and the 1-cycle write protocol, and assembles or extends read data. It stalls IO writes while the UART buffer is full.

## Interface
- ADDR_W, 32, width of request and bus addresses
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- rdy  in  1  global ready; low freezes the block
- io_buffer_full  in  1  UART TX buffer full
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch byte address
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  fetched word, little-endian
- ls_req  in  1  load/store request, held until ls_done
- ls_we  in  1  1 = store, 0 = load
- ls_size  in  2  0 = byte, 1 = half, 2 = word (3 is treated as word)
- ls_signed  in  1  sign-extend load result
- ls_addr  in  ADDR_W  load/store byte address
- ls_wdata  in  32  store data, low bytes used
- ls_done  out  1  one-cycle pulse, access complete
- ls_rdata  out  32  extended load result
- mem_din  in  8  memory read data
- mem_dout  out  8  memory write data
- mem_a  out  ADDR_W  memory address
- mem_wr  out  1  1 = write

## Operation
- States: IDLE, READ, WRITE.
- Counters:
  - n = byte count: IF = 4; LS = 1, 2 or 4 per ls_size.
  - iss = bytes issued.
  - rcv = bytes received.
- Arbitration happens only in IDLE. ls_req beats if_req. The winning requester's operands are latched at acceptance.
- Requests are not accepted in the cycle when either done is high. In the cycle it sees done, a requester either drops req or presents a new request.
- READ:
  - mem_a steps through addr, addr+1, …, addr+n-1, one per cycle, with mem_wr = 0.
  - Byte k is sampled from mem_din two edges after its address was registered, into bits [8k+7:8k].
- Load extension:
  - Byte loads replicate bit 7 into [31:8] if ls_signed, else zero-fill.
  - Half loads replicate bit 15 into [31:16] if ls_signed, else zero-fill.
  - Word loads are passed through.
- WRITE: mem_a = addr+k, mem_dout = wdata[8k+7:8k], mem_wr = 1, for k = 0..n-1 on consecutive cycles.
- IO stall: a write byte whose address[17:16] == 2'b11 is not issued while io_buffer_full is high. During the stall, mem_wr = 0 and iss holds.
- Addresses wrap mod 2^ADDR_W. No alignment checks. Misaligned accesses are performed byte-wise.
- rdy low: all registers hold and mem_wr is forced to 0 combinationally. Operation resumes exactly where it stopped.
- Reset asserted mid-transaction aborts it immediately. No done is produced.

## Timing
- Reset values: state IDLE, mem_a 0, mem_dout 0, mem_wr 0, if_done 0, ls_done 0, if_data 0, ls_rdata 0.
- Read:
  - Accept edge E0 registers mem_a = addr.
  - Edges E1..E(n-1) register the following addresses.
  - Byte k is sampled at E(k+2).
  - The data output and done are registered at E(n+1).
  - Done is high in the cycle after E(n+1).
  - Word: 6 cycles from accept to done cycle. Byte: 3 cycles.
- Write:
  - Bytes are registered at E0..E(n-1).
  - At E(n): mem_wr <= 0 and done <= 1.
  - Word store: done in cycle 5. Byte store: done in cycle 2.
- Done is a single-cycle pulse. if_done and ls_done are never high together.
- Back-to-back: minimum one IDLE cycle (the done cycle) between transactions.

## Test plan
- Fetch word: if_req, if_addr = 0x100, RAM[0x100..0x103] = 13 05 10 00 -> mem_a = 0x100..0x103 on consecutive cycles, if_done in cycle 6, if_data = 0x00100513.
- Signed/unsigned loads:
  - LB at 0x20, RAM = 0x80: ls_signed = 1 gives ls_rdata = 0xFFFFFF80; ls_signed = 0 gives 0x00000080.
  - LH at 0x21 = 34 92 (misaligned): ls_signed = 1 gives 0xFFFF9234.
- Store word: ls_we = 1, ls_size = 2, ls_addr = 0x1FFFE, ls_wdata = 0xDEADBEEF -> writes EF BE AD DE to 0x1FFFE..0x20001, mem_wr high 4 cycles, ls_done in cycle 5.
- Arbitration: if_req and ls_req raised in the same cycle -> LS served first; IF accepted the cycle after ls_done; no done overlap.
- IO stall: SB 0x41 to 0x30000 with io_buffer_full = 1 for 10 cycles -> mem_wr stays 0; byte is written the cycle after full drops; ls_done one cycle later.
- Freeze/reset:
  - rdy low for 3 cycles mid word-read -> result is identical, latency +3, mem_wr = 0 throughout.
  - rst low mid-store -> all outputs return to reset values immediately, no ls_done.

Source files
------------

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl -- byte-serial memory controller and arbiter
//
// Shares one 8-bit RAM/IO port between the instruction-fetch requester
// (always 4-byte reads) and the load/store requester (1/2/4-byte reads or
// writes). Reads use a pipelined protocol: an address registered on one edge
// returns its byte on mem_din in time to be sampled two edges later. Writes
// put one byte per cycle on the bus. Stores into the IO segment
// (address[17:16] == 2'b11) wait while the UART TX buffer is full.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   rdy                global ready; low freezes every register
//   io_buffer_full     UART TX buffer full, stalls IO-segment store bytes
//   if_req/if_addr     fetch request (4-byte read), held until if_done
//   if_done/if_data    one-cycle completion pulse, little-endian fetched word
//   ls_req/ls_we/ls_size/ls_signed/ls_addr/ls_wdata
//                      load/store request, held until ls_done
//   ls_done/ls_rdata   one-cycle completion pulse, extended load result
//   mem_din            memory read data
//   mem_dout/mem_a/mem_wr
//                      memory write data, address, write strobe
// -----------------------------------------------------------------------------
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              io_buffer_full,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic              ls_signed,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  // True when the address segment bits select the UART/IO region.
  function automatic logic is_io_seg(input logic [1:0] seg);
    return (seg == 2'b11);
  endfunction

  // Byte count of a load/store; size 3 behaves as a word.
  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      2'd0:    n = 3'd1;
      2'd1:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Sign- or zero-extend an assembled load result to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    logic [31:0] res;
    case (size)
      2'd0:    res = sgn ? {{24{word[7]}}, word[7:0]} : {24'd0, word[7:0]};
      2'd1:    res = sgn ? {{16{word[15]}}, word[15:0]} : {16'd0, word[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Transaction state
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          n_q, n_d;
  logic [2:0]          iss_q, iss_d;
  logic [2:0]          rcv_q, rcv_d;
  // pipe_q[0]: an address was issued on the previous edge;
  // pipe_q[1]: an address was issued two edges ago, so its byte is on mem_din.
  logic [1:0]          pipe_q, pipe_d;
  logic                is_ls_q, is_ls_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rbuf_q, rbuf_d;

  // Registered outputs
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                mem_wr_q, mem_wr_d;
  logic                if_done_q, if_done_d;
  logic                ls_done_q, ls_done_d;
  logic [31:0]         if_data_q, if_data_d;
  logic [31:0]         ls_rdata_q, ls_rdata_d;

  // Arbitration and datapath helpers
  logic                acc_go_s;
  logic [ADDR_W-1:0]   acc_addr_s;
  logic [2:0]          acc_n_s;
  logic                acc_we_s;
  logic [ADDR_W-1:0]   cur_addr_s;
  logic [7:0]          wr_byte_s;
  logic [31:0]         rd_word_s;
  logic                rd_issue_s;

  // Load/store wins over fetch; nothing is accepted while a done pulse is out,
  // so the done cycle is always the one idle cycle between transactions.
  assign acc_go_s   = (ls_req | if_req) & ~if_done_q & ~ls_done_q;
  assign acc_addr_s = ls_req ? ls_addr : if_addr;
  assign acc_n_s    = ls_req ? size_to_n(ls_size) : 3'd4;
  assign acc_we_s   = ls_req & ls_we;

  // Address of the next byte to issue; wraps naturally at 2^ADDR_W.
  assign cur_addr_s = addr_q + ADDR_W'(iss_q);
  assign wr_byte_s  = wdata_q[{iss_q[1:0], 3'b000} +: 8];
  assign rd_word_s  = rbuf_q | ({24'd0, mem_din} << {rcv_q[1:0], 3'b000});
  assign rd_issue_s = (iss_q < n_q);

  // Next-state and next-output logic for the IDLE/READ/WRITE sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    n_d        = n_q;
    iss_d      = iss_q;
    rcv_d      = rcv_q;
    pipe_d     = pipe_q;
    is_ls_d    = is_ls_q;
    size_d     = size_q;
    signed_d   = signed_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (acc_go_s) begin
          addr_d   = acc_addr_s;
          n_d      = acc_n_s;
          is_ls_d  = ls_req;
          size_d   = ls_size;
          signed_d = ls_signed;
          wdata_d  = ls_wdata;
          rbuf_d   = 32'd0;
          rcv_d    = 3'd0;
          mem_a_d  = acc_addr_s;
          if (acc_we_s) begin
            // The first store byte goes out on the accept edge unless it
            // targets the IO segment while the UART buffer is full.
            state_d    = WRITE;
            pipe_d     = 2'b00;
            mem_dout_d = ls_wdata[7:0];
            if (is_io_seg(acc_addr_s[17:16]) && io_buffer_full) begin
              mem_wr_d = 1'b0;
              iss_d    = 3'd0;
            end else begin
              mem_wr_d = 1'b1;
              iss_d    = 3'd1;
            end
          end else begin
            state_d  = READ;
            mem_wr_d = 1'b0;
            iss_d    = 3'd1;
            pipe_d   = 2'b01;
          end
        end else begin
          mem_wr_d = 1'b0;
        end
      end

      READ: begin
        mem_wr_d = 1'b0;
        pipe_d   = {pipe_q[0], rd_issue_s};
        if (rd_issue_s) begin
          mem_a_d = cur_addr_s;
          iss_d   = iss_q + 3'd1;
        end else begin
          iss_d   = iss_q;
        end
        if (pipe_q[1]) begin
          rbuf_d = rd_word_s;
          rcv_d  = rcv_q + 3'd1;
          // The last byte is folded straight into the result register on
          // the same edge it is sampled.
          if (rcv_q == (n_q - 3'd1)) begin
            state_d = IDLE;
            pipe_d  = 2'b00;
            if (is_ls_q) begin
              ls_rdata_d = extend_load(rd_word_s, size_q, signed_q);
              ls_done_d  = 1'b1;
            end else begin
              if_data_d  = rd_word_s;
              if_done_d  = 1'b1;
            end
          end else begin
            state_d = READ;
          end
        end else begin
          rcv_d = rcv_q;
        end
      end

      WRITE: begin
        if (rd_issue_s) begin
          mem_a_d    = cur_addr_s;
          mem_dout_d = wr_byte_s;
          // A stalled IO byte keeps iss so it is retried every cycle.
          if (is_io_seg(cur_addr_s[17:16]) && io_buffer_full) begin
            mem_wr_d = 1'b0;
            iss_d    = iss_q;
          end else begin
            mem_wr_d = 1'b1;
            iss_d    = iss_q + 3'd1;
          end
        end else begin
          mem_wr_d  = 1'b0;
          ls_done_d = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  // State and output registers; rdy low holds everything in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      n_q        <= 3'd0;
      iss_q      <= 3'd0;
      rcv_q      <= 3'd0;
      pipe_q     <= 2'b00;
      is_ls_q    <= 1'b0;
      size_q     <= 2'd0;
      signed_q   <= 1'b0;
      wdata_q    <= 32'd0;
      rbuf_q     <= 32'd0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
    end else if (rdy) begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      n_q        <= n_d;
      iss_q      <= iss_d;
      rcv_q      <= rcv_d;
      pipe_q     <= pipe_d;
      is_ls_q    <= is_ls_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  // A frozen cycle must never write, even mid-store.
  assign mem_wr   = mem_wr_q & rdy;
  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl -- self-checking bench for mem_ctrl
//
// A transaction-level model predicts bus activity and results from the
// protocol rules (byte k of a read at address+k, result after n+2 cycles,
// one store byte per unstalled cycle). A compare process checks the DUT
// against it every cycle; directed tests pin latencies and data with
// hand-computed literals.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        io_buffer_full = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [1:0]  ls_size = 2'd0;
  logic        ls_signed = 1'b0;
  logic [31:0] ls_addr = 32'd0;
  logic [31:0] ls_wdata = 32'd0;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_signed(ls_signed),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // ---------------- bus memory (driven by the DUT) and model memory ----------
  logic [7:0] ram  [logic [31:0]];
  logic [7:0] mram [logic [31:0]];

  function automatic logic [7:0] rd_ram(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rd_mram(input logic [31:0] a);
    return mram.exists(a) ? mram[a] : 8'h00;
  endfunction

  task automatic put(input logic [31:0] a, input logic [7:0] d);
    ram[a]  = d;
    mram[a] = d;
  endtask

  // Registered-read memory: data for the address seen at one edge is
  // presented after the next edge.
  always @(posedge clk) begin
    if (rdy) mem_din <= rd_ram(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  // ---------------- transaction-level model ----------------------------------
  bit          m_busy = 1'b0, m_rd = 1'b0, m_ls = 1'b0, m_sgn = 1'b0, m_pend = 1'b0;
  logic [31:0] m_addr = 32'd0, m_wdata = 32'd0, m_result = 32'd0;
  logic [1:0]  m_size = 2'd0;
  int          m_n = 0, m_t = 0, m_k = 0;
  logic [31:0] e_mem_a = 32'd0, e_if_data = 32'd0, e_ls_rdata = 32'd0;
  logic [7:0]  e_mem_dout = 8'd0;
  bit          e_mem_wr = 1'b0, e_if_done = 1'b0, e_ls_done = 1'b0, e_a_valid = 1'b0;

  function automatic logic [31:0] gather(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = rd_mram(a + 32'(i));
    return w;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] sz, input bit sg);
    if (sz == 2'd0) return sg ? {{24{w[7]}}, w[7:0]} : {24'd0, w[7:0]};
    if (sz == 2'd1) return sg ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
    return w;
  endfunction

  task automatic wr_step();
    logic [31:0] a;
    if (m_k < m_n) begin
      a = m_addr + 32'(m_k);
      e_mem_a    = a;
      e_mem_dout = m_wdata[8*m_k +: 8];
      if (a[17:16] == 2'b11 && io_buffer_full) begin
        e_mem_wr  = 1'b0;
        e_a_valid = 1'b0;
      end else begin
        e_mem_wr  = 1'b1;
        e_a_valid = 1'b1;
        mram[a]   = e_mem_dout;
        m_k++;
      end
    end else begin
      e_mem_wr  = 1'b0;
      e_a_valid = 1'b0;
      e_ls_done = 1'b1;
      m_busy    = 1'b0;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0; e_mem_a = 32'd0; e_mem_dout = 8'd0; e_mem_wr = 1'b0;
      e_if_done = 1'b0; e_ls_done = 1'b0; e_if_data = 32'd0; e_ls_rdata = 32'd0;
      e_a_valid = 1'b1;
    end else if (rdy) begin
      m_pend    = e_if_done | e_ls_done;
      e_if_done = 1'b0;
      e_ls_done = 1'b0;
      e_a_valid = 1'b0;
      if (!m_busy) begin
        if (!m_pend && (ls_req || if_req)) begin
          m_busy  = 1'b1;
          m_ls    = ls_req;
          m_addr  = ls_req ? ls_addr : if_addr;
          m_rd    = !(ls_req && ls_we);
          m_n     = !ls_req ? 4 : (ls_size == 2'd0 ? 1 : (ls_size == 2'd1 ? 2 : 4));
          m_size  = ls_size;
          m_sgn   = ls_signed;
          m_wdata = ls_wdata;
          m_t     = 0;
          m_k     = 0;
          if (m_rd) begin
            m_result  = gather(m_addr, m_n);
            if (m_ls) m_result = ext(m_result, m_size, m_sgn);
            e_mem_a   = m_addr;
            e_a_valid = 1'b1;
            e_mem_wr  = 1'b0;
          end else begin
            wr_step();
          end
        end
      end else if (m_rd) begin
        m_t++;
        if (m_t < m_n) begin
          e_mem_a   = m_addr + 32'(m_t);
          e_a_valid = 1'b1;
        end
        if (m_t == m_n + 1) begin
          m_busy = 1'b0;
          if (m_ls) begin
            e_ls_done = 1'b1; e_ls_rdata = m_result;
          end else begin
            e_if_done = 1'b1; e_if_data = m_result;
          end
        end
      end else begin
        wr_step();
      end
    end
  end

  // ---------------- per-cycle compare against the model ---------------------
  initial forever begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      chk("mem_wr", 32'(mem_wr), 32'(e_mem_wr & rdy));
      if (e_mem_wr && rdy) chk("mem_dout", 32'(mem_dout), 32'(e_mem_dout));
      if (e_a_valid) chk("mem_a", mem_a, e_mem_a);
      chk("if_done", 32'(if_done), 32'(e_if_done));
      chk("ls_done", 32'(ls_done), 32'(e_ls_done));
      chk("if_data", if_data, e_if_data);
      chk("ls_rdata", ls_rdata, e_ls_rdata);
      chk("done_excl", 32'(if_done & ls_done), 32'd0);
    end
  end

  // ---------------- requester tasks ------------------------------------------
  task automatic run_if(input logic [31:0] a, output int cyc, output logic [31:0] dat);
    @(negedge clk);
    if_req = 1'b1; if_addr = a;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1; cyc++;
      if (if_done) break;
    end
    chk("if_timeout", 32'(if_done), 32'd1);
    dat = if_data;
    @(negedge clk);
    if_req = 1'b0;
  endtask

  task automatic run_ls(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int cyc, output logic [31:0] dat, output int wrc);
    @(negedge clk);
    ls_req = 1'b1; ls_we = we; ls_size = sz; ls_signed = sg; ls_addr = a; ls_wdata = wd;
    cyc = 0; wrc = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1; cyc++;
      if (mem_wr) wrc++;
      if (ls_done) break;
    end
    chk("ls_timeout", 32'(ls_done), 32'd1);
    dat = ls_rdata;
    @(negedge clk);
    ls_req = 1'b0; ls_we = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_a"},    mem_a, 32'd0);
    chk({tag, "_mem_dout"}, 32'(mem_dout), 32'd0);
    chk({tag, "_mem_wr"},   32'(mem_wr), 32'd0);
    chk({tag, "_if_done"},  32'(if_done), 32'd0);
    chk({tag, "_ls_done"},  32'(ls_done), 32'd0);
    chk({tag, "_if_data"},  if_data, 32'd0);
    chk({tag, "_ls_rdata"}, ls_rdata, 32'd0);
  endtask

  // ---------------- directed sequence ----------------------------------------
  initial begin
    int          cyc, wrc, ls_c, if_c, ovl, first_wr, done_c, cnt;
    logic [31:0] dat;

    put(32'h100, 8'h13); put(32'h101, 8'h05); put(32'h102, 8'h10); put(32'h103, 8'h00);
    put(32'h20, 8'h80);  put(32'h21, 8'h34);  put(32'h22, 8'h92);

    #1 rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk) rst = 1'b1;

    // Fetch word
    run_if(32'h100, cyc, dat);
    chk("fetch_lat", 32'(cyc), 32'd6);
    chk("fetch_data", dat, 32'h00100513);

    // Byte loads, signed and unsigned
    run_ls(1'b0, 2'd0, 1'b1, 32'h20, 32'd0, cyc, dat, wrc);
    chk("lb_s_lat", 32'(cyc), 32'd3);
    chk("lb_s_data", dat, 32'hFFFFFF80);
    run_ls(1'b0, 2'd0, 1'b0, 32'h20, 32'd0, cyc, dat, wrc);
    chk("lb_u_data", dat, 32'h00000080);

    // Misaligned half loads
    run_ls(1'b0, 2'd1, 1'b1, 32'h21, 32'd0, cyc, dat, wrc);
    chk("lh_s_lat", 32'(cyc), 32'd4);
    chk("lh_s_data", dat, 32'hFFFF9234);
    run_ls(1'b0, 2'd1, 1'b0, 32'h21, 32'd0, cyc, dat, wrc);
    chk("lh_u_data", dat, 32'h00009234);

    // Store word across 0x20000, then read it back
    run_ls(1'b1, 2'd2, 1'b0, 32'h1FFFE, 32'hDEADBEEF, cyc, dat, wrc);
    chk("sw_lat", 32'(cyc), 32'd5);
    chk("sw_wr_cycles", 32'(wrc), 32'd4);
    chk("sw_bytes", {rd_ram(32'h20001), rd_ram(32'h20000), rd_ram(32'h1FFFF), rd_ram(32'h1FFFE)},
        32'hDEADBEEF);
    run_ls(1'b0, 2'd2, 1'b0, 32'h1FFFE, 32'd0, cyc, dat, wrc);
    chk("lw_back", dat, 32'hDEADBEEF);

    // Arbitration: both requests in the same cycle
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_signed = 1'b1; ls_addr = 32'h20;
    cyc = 0; ls_c = 0; if_c = 0; ovl = 0;
    for (int i = 0; i < 100 && if_c == 0; i++) begin
      @(posedge clk); #1; cyc++;
      if (if_done && ls_done) ovl++;
      if (ls_done && ls_c == 0) ls_c = cyc;
      if (if_done) if_c = cyc;
      @(negedge clk);
      if (ls_c != 0) ls_req = 1'b0;
      if (if_c != 0) if_req = 1'b0;
    end
    chk("arb_ls_cycle", 32'(ls_c), 32'd3);
    chk("arb_if_cycle", 32'(if_c), 32'd10);
    chk("arb_overlap", 32'(ovl), 32'd0);
    if_req = 1'b0; ls_req = 1'b0;

    // IO stall: full for 10 cycles
    @(negedge clk);
    io_buffer_full = 1'b1;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h41;
    cyc = 0; first_wr = 0; wrc = 0; done_c = 0;
    for (int i = 0; i < 100 && done_c == 0; i++) begin
      @(posedge clk); #1; cyc++;
      if (mem_wr) begin
        wrc++;
        if (first_wr == 0) first_wr = cyc;
      end
      if (ls_done) done_c = cyc;
      @(negedge clk);
      if (cyc == 10) io_buffer_full = 1'b0;
      if (done_c != 0) begin ls_req = 1'b0; ls_we = 1'b0; end
    end
    chk("io_first_wr", 32'(first_wr), 32'd11);
    chk("io_wr_cycles", 32'(wrc), 32'd1);
    chk("io_done_cycle", 32'(done_c), 32'd12);
    chk("io_byte", 32'(rd_ram(32'h30000)), 32'h41);
    io_buffer_full = 1'b0; ls_req = 1'b0; ls_we = 1'b0;

    // Freeze: rdy low for 3 edges mid word fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    cyc = 0; wrc = 0; done_c = 0;
    for (int i = 0; i < 100 && done_c == 0; i++) begin
      @(posedge clk); #1; cyc++;
      if (mem_wr) wrc++;
      if (if_done) done_c = cyc;
      @(negedge clk);
      if (cyc == 2) rdy = 1'b0;
      if (cyc == 5) rdy = 1'b1;
      if (done_c != 0) if_req = 1'b0;
    end
    chk("frz_lat", 32'(done_c), 32'd9);
    chk("frz_data", if_data, 32'h00100513);
    chk("frz_no_wr", 32'(wrc), 32'd0);
    rdy = 1'b1; if_req = 1'b0;

    // Reset in the middle of a word store
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h500; ls_wdata = 32'h11223344;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_pre_wr", 32'(mem_wr), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    ls_req = 1'b0; ls_we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ls_done) cnt++;
    end
    chk("rst_no_done", 32'(cnt), 32'd0);

    // Normal operation after reset
    run_ls(1'b0, 2'd0, 1'b0, 32'h100, 32'd0, cyc, dat, wrc);
    chk("post_rst_lb", dat, 32'h00000013);

    repeat (2) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
